// File: rtl/vproc_result_arb.sv
// Result arbiter: merges NUM_SRC producer channels, each behind a small bypassing FIFO, onto the XIF result channel.
// Macros: VPROC_RESULT_ARB_RR_EN (round-robin arbitration), VPROC_RESULT_ARB_PROTO_ASSERT (valid-while-not-ready check).
module vproc_result_arb #(
    parameter int unsigned XIF_ID_W       = 3,
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned BUF_DEPTH      = 2,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         async_rst_ni,
    input  logic                         sync_rst_ni,

    input  logic [NUM_SRC-1:0]           src_valid_i,
    output logic [NUM_SRC-1:0]           src_ready_o,
    input  logic [NUM_SRC*XIF_ID_W-1:0]  src_id_i,
    input  logic [NUM_SRC*32-1:0]        src_data_i,
    input  logic [NUM_SRC*5-1:0]         src_rd_i,
    input  logic [NUM_SRC-1:0]           src_we_i,
    input  logic [NUM_SRC-1:0]           src_exc_i,
    input  logic [NUM_SRC*6-1:0]         src_exccode_i,

    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic [XIF_ID_W-1:0]          result_id_o,
    output logic [31:0]                  result_data_o,
    output logic [4:0]                   result_rd_o,
    output logic                         result_we_o,
    output logic                         result_exc_o,
    output logic [5:0]                   result_exccode_o
);

    // Handshake: a beat moves when valid & ready are both high at the clock edge; ready never
    // depends on valid, and src_ready_o depends on registered FIFO counts only.

    localparam int unsigned PAY_W = XIF_ID_W + 32 + 5 + 1 + 1 + 6;
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

    // Payload layout: {id, data, rd, we, exc, exccode}
    logic [PAY_W-1:0] src_pay   [NUM_SRC];
    logic [PAY_W-1:0] cand_pay  [NUM_SRC];
    logic [PAY_W-1:0] res_pay;

    logic [CNT_W-1:0] cnt_q     [NUM_SRC];
    logic [CNT_W-1:0] cnt_d     [NUM_SRC];
    logic [PTR_W-1:0] wr_ptr_q  [NUM_SRC];
    logic [PTR_W-1:0] wr_ptr_d  [NUM_SRC];
    logic [PTR_W-1:0] rd_ptr_q  [NUM_SRC];
    logic [PTR_W-1:0] rd_ptr_d  [NUM_SRC];
    logic [PAY_W-1:0] mem_q     [NUM_SRC][BUF_DEPTH];
    logic [PAY_W-1:0] mem_d     [NUM_SRC][BUF_DEPTH];

    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] bypass;
    logic [IDX_W-1:0]   gnt_idx;
    logic               any_elig;
    logic               transfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        for (int c = 0; c < int'(NUM_SRC); c++) begin
            src_pay[c] = {src_id_i[c*XIF_ID_W +: XIF_ID_W], src_data_i[c*32 +: 32],
                          src_rd_i[c*5 +: 5], src_we_i[c], src_exc_i[c],
                          src_exccode_i[c*6 +: 6]};
        end
    end

    // Candidates: FIFO head when occupied, otherwise the incoming beat (bypass)
    always_comb begin
        for (int c = 0; c < int'(NUM_SRC); c++) begin
            src_ready_o[c] = (cnt_q[c] != CNT_FULL);
            accept[c]      = src_valid_i[c] & src_ready_o[c];
            eligible[c]    = (cnt_q[c] != '0) | accept[c];
            cand_pay[c]    = (cnt_q[c] != '0) ? mem_q[c][rd_ptr_q[c]] : src_pay[c];
        end
    end

    assign any_elig = |eligible;
    assign transfer = any_elig & result_ready_i;

`ifdef VPROC_RESULT_ARB_RR_EN
    localparam logic [NUM_SRC-1:0] LAST_RST = NUM_SRC'(1) << (NUM_SRC - 1);

    logic [NUM_SRC-1:0] last_gnt_q;
    logic [NUM_SRC-1:0] last_gnt_d;

    // Search starts just after the last granted channel and wraps around
    always_comb begin
        int last_idx;
        int idx;
        logic found;
        last_idx = 0;
        idx      = 0;
        found    = 1'b0;
        gnt_idx  = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (last_gnt_q[i]) begin
                last_idx = i;
            end
        end
        for (int k = 1; k <= int'(NUM_SRC); k++) begin
            idx = last_idx + k;
            if (idx >= int'(NUM_SRC)) begin
                idx = idx - int'(NUM_SRC);
            end
            if (!found && eligible[idx]) begin
                gnt_idx = IDX_W'(idx);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (!sync_rst_ni) begin
            last_gnt_d = LAST_RST;
        end else if (transfer) begin
            last_gnt_d          = '0;
            last_gnt_d[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            last_gnt_q <= LAST_RST;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    always_comb begin
        gnt_idx = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        res_pay = cand_pay[gnt_idx];
        if (!any_elig) begin
            res_pay = DONT_CARE_ZERO ? '0 : 'x;
        end
    end

    assign result_valid_o   = any_elig;
    assign result_id_o      = res_pay[PAY_W-1 -: XIF_ID_W];
    assign result_data_o    = res_pay[44:13];
    assign result_rd_o      = res_pay[12:8];
    assign result_we_o      = any_elig & res_pay[7];
    assign result_exc_o     = any_elig & res_pay[6];
    assign result_exccode_o = res_pay[5:0];

    // A bypassed beat goes straight out and never occupies a FIFO slot
    always_comb begin
        mem_d = mem_q;
        for (int c = 0; c < int'(NUM_SRC); c++) begin
            pop[c]      = transfer && (gnt_idx == IDX_W'(c)) && (cnt_q[c] != '0);
            bypass[c]   = transfer && (gnt_idx == IDX_W'(c)) && (cnt_q[c] == '0);
            push[c]     = accept[c] && !bypass[c];
            cnt_d[c]    = cnt_q[c];
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = src_pay[c];
                wr_ptr_d[c]           = ptr_inc(wr_ptr_q[c]);
            end
            if (pop[c]) begin
                rd_ptr_d[c] = ptr_inc(rd_ptr_q[c]);
            end
            if (push[c] && !pop[c]) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end else if (pop[c] && !push[c]) begin
                cnt_d[c] = cnt_q[c] - 1'b1;
            end
            if (!sync_rst_ni) begin
                cnt_d[c]    = '0;
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            for (int c = 0; c < int'(NUM_SRC); c++) begin
                cnt_q[c]    <= '0;
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifdef VPROC_RESULT_ARB_PROTO_ASSERT
    always @(posedge clk_i) begin
        if (async_rst_ni && sync_rst_ni) begin
            assert ((src_valid_i & ~src_ready_o) == '0)
                else $error("src_valid_i asserted on a channel that is not ready");
        end
    end
`endif

endmodule

// File: doc/vproc_result_arb.md
Name: vproc_result_arb

Overview:
- Generalised result arbiter for the vector coprocessor.
- Collects completion results from NUM_SRC independent producer channels (LSU, XREG writeback, empty, CFG/vl, …) and drives the single XIF result channel toward the host core.
- Each channel has its own BUF_DEPTH-entry FIFO with same-cycle bypass.
- Arbitration is fixed-priority by default (lower index wins); round-robin is available as a compile-time option.

Parameters:
- XIF_ID_W, 3, width in bits of instruction IDs
- NUM_SRC, 4, number of producer channels (2..8)
- BUF_DEPTH, 2, FIFO entries per channel (1..8)
- DONT_CARE_ZERO, 1'b0, drive don't-care output fields to 0 instead of X

Ports:
- clk_i  in  1  clock
- async_rst_ni  in  1  asynchronous active-low reset
- sync_rst_ni  in  1  synchronous active-low reset (flush)
- src_valid_i  in  NUM_SRC  per-channel result valid
- src_ready_o  out  NUM_SRC  per-channel ready (FIFO not full)
- src_id_i  in  NUM_SRC*XIF_ID_W  instruction ID per channel
- src_data_i  in  NUM_SRC*32  writeback data per channel
- src_rd_i  in  NUM_SRC*5  destination x-register per channel
- src_we_i  in  NUM_SRC  x-register write enable per channel
- src_exc_i  in  NUM_SRC  exception flag per channel
- src_exccode_i  in  NUM_SRC*6  exception code per channel
- result_valid_o  out  1  XIF result valid
- result_ready_i  in  1  XIF result ready
- result_id_o  out  XIF_ID_W  result ID
- result_data_o  out  32  result data
- result_rd_o  out  5  result rd
- result_we_o  out  1  result write enable
- result_exc_o  out  1  result exception flag
- result_exccode_o  out  6  result exception code

Behaviour:
- Reset: async_rst_ni is asynchronous, active-low, on clock clk_i.
  - Both resets clear all per-channel counts and rd/wr pointers.
  - After reset: result_valid_o=0, result_we_o=0, result_exc_o=0, src_ready_o=all 1s.
  - Payload registers are not reset.
- FIFO state per channel c:
  - cnt[c] in 0..BUF_DEPTH; wr/rd pointers wrap modulo BUF_DEPTH (non-power-of-2 depths must wrap correctly).
  - src_ready_o[c] = (cnt[c] != BUF_DEPTH). It is a function of registers only; there is no combinational path from result_ready_i.
- Accept: src_valid_i[c] & src_ready_o[c]. src_valid_i while not ready is a protocol error (SVA) and is ignored.
- Candidate per channel:
  - FIFO head if cnt[c]>0.
  - Otherwise the accepted input (bypass).
  - A channel is eligible if cnt[c]>0 or an accept occurs.
- Selection:
  - Fixed priority: lowest eligible index wins.
  - result_valid_o = any eligible; payload is muxed from the winner's candidate.
  - If no channel is eligible: fields other than valid/we/exc = DONT_CARE_ZERO ? 0 : X.
  - we/exc are forced to 0 when result_valid_o=0.
- Transfer = result_valid_o & result_ready_i.
  - Winner with cnt>0: pop head.
  - Winner bypassing: the input is not written into the FIFO (zero-latency).
- Per-channel update in one cycle:
  - push only: cnt+1
  - pop only: cnt-1
  - push+pop: cnt unchanged, both pointers advance
  - bypass: cnt unchanged
- Ordering:
  - FIFO order is preserved within a channel.
  - No ordering guarantee across channels.
- Latency: 0 cycles via bypass when the channel's FIFO is empty and it wins; otherwise ≥1 cycle.
- Full FIFO with simultaneous pop: ready stays 0 that cycle (registered), so no push occurs; ready rises the next cycle.
- sync_rst_ni low mid-transfer:
  - Contents are discarded next edge.
  - result_valid_o is not masked during the reset cycle; the consumer ignores it.

Optional Feature:
- Macro: VPROC_RESULT_ARB_RR_EN.
- When defined: round-robin arbitration with a NUM_SRC-bit one-hot last-grant register (reset to bit NUM_SRC-1).
  - Search starts at last grant+1 and wraps around.
  - The pointer updates only on a transfer.
- When undefined: fixed priority as above, and no grant register is instantiated.

Test Plan:
- Reset, then ch1 valid with id=5, data=0x1234, rd=7, we=1, result_ready_i=1 → same-cycle result_valid_o=1, id=5, data=0x1234, rd=7, we=1; cnt[1] remains 0.
- result_ready_i=0, push ch0 three times with BUF_DEPTH=2 → ready[0] drops after 2 pushes; third valid ignored; releasing ready yields ids in push order.
- ch0 and ch2 valid same cycle, ready=1 → ch0 (id=1) output immediately, ch2 (id=3) buffered and output next cycle.
- Full ch3 with simultaneous push attempt and pop → cnt stays 1 after pop, ready[3] returns to 1 the following cycle, no data loss.
- sync_rst_ni pulsed while ch0 holds 2 entries → next cycle result_valid_o=0, src_ready_o=all 1s.
- VPROC_RESULT_ARB_RR_EN, channels 0..3 continuously valid, ready=1 → grants cycle 0,1,2,3,0…; without the macro, grants stay on 0.
